// File: rtl/cycle_sequencer_pkg.sv
// cycle_sequencer_pkg
//   Shared constants for the instruction-phase sequencer: phase-vector width
//   and bit positions, state encodings and the default retired-count width.
package cycle_sequencer_pkg;

   localparam int unsigned CYCLE_WIDTH  = 3;
   localparam int unsigned CYCLE_FETCH  = 0;
   localparam int unsigned CYCLE_DECODE = 1;
   localparam int unsigned CYCLE_EXEC   = 2;

   localparam int unsigned ICOUNT_WIDTH = 16;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      WAIT   = 3'd2,
      EXEC   = 3'd3,
      HALT   = 3'd4
   } cycle_state_t;

endpackage

// File: rtl/cycle_sequencer_if.sv
// cycle_sequencer_if
//   Bundles the sequencer's control inputs and phase/status outputs.
//   master : drives run_mode, step_btn, stall, halt; observes cycle, halted, icount
//   slave  : the sequencer itself
interface cycle_sequencer_if #(
   parameter int unsigned CYCLE_WIDTH  = cycle_sequencer_pkg::CYCLE_WIDTH,
   parameter int unsigned ICOUNT_WIDTH = cycle_sequencer_pkg::ICOUNT_WIDTH
);
   logic                    run_mode;
   logic                    step_btn;
   logic                    stall;
   logic                    halt;
   logic [CYCLE_WIDTH-1:0]  cycle;
   logic                    halted;
   logic [ICOUNT_WIDTH-1:0] icount;

   modport master (
      output run_mode, step_btn, stall, halt,
      input  cycle, halted, icount
   );

   modport slave (
      input  run_mode, step_btn, stall, halt,
      output cycle, halted, icount
   );
endinterface

// File: rtl/cycle_sequencer_synchroniser.sv
// synchroniser
//   STAGES-deep flop chain per bit for bringing asynchronous levels into the
//   clk domain. Clears to 0 on reset.
//   clk     : system clock
//   n_reset : asynchronous active-low reset
//   i_d     : asynchronous inputs
//   o_q     : synchronised outputs
module synchroniser #(
   parameter int unsigned WIDTH  = 1,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             n_reset,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);
   logic [STAGES-1:0][WIDTH-1:0] r_stage;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_stage <= '0;
      end else begin
         r_stage[0] <= i_d;
         for (int unsigned i = 1; i < STAGES; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign o_q = r_stage[STAGES-1];
endmodule

// File: rtl/cycle_sequencer.sv
// cycle_sequencer
//   Produces the one-hot instruction phase vector (FETCH/DECODE/EXEC) with
//   free-run / single-step control, execute stalls, sticky halt and a
//   saturating retired-instruction counter.
//   clk     : system clock
//   n_reset : asynchronous active-low reset
//   bus     : run_mode, step_btn (async), stall, halt (sync) in;
//             cycle, halted, icount out
module cycle_sequencer
   import cycle_sequencer_pkg::*;
#(
   parameter int unsigned CYCLE_WIDTH  = cycle_sequencer_pkg::CYCLE_WIDTH,
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned ICOUNT_WIDTH = cycle_sequencer_pkg::ICOUNT_WIDTH
) (
   input  logic               clk,
   input  logic               n_reset,
   cycle_sequencer_if.slave   bus
);
   localparam logic [2:0] ST_FETCH  = FETCH;
   localparam logic [2:0] ST_DECODE = DECODE;
   localparam logic [2:0] ST_WAIT   = WAIT;
   localparam logic [2:0] ST_EXEC   = EXEC;
   localparam logic [2:0] ST_HALT   = HALT;

   logic [1:0]              w_sync_out;
   logic                    w_run_s;
   logic                    w_step_s;
   logic                    w_step_pulse;
   logic                    r_step_prev;
   logic [2:0]              r_state;
   logic [2:0]              w_next;
   logic [ICOUNT_WIDTH-1:0] r_icount;
   logic [CYCLE_WIDTH-1:0]  w_cycle;

   synchroniser #(
      .WIDTH  (2),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .n_reset (n_reset),
      .i_d     ({bus.step_btn, bus.run_mode}),
      .o_q     (w_sync_out)
   );

   assign w_run_s      = w_sync_out[0];
   assign w_step_s     = w_sync_out[1];
   assign w_step_pulse = w_step_s & ~r_step_prev;

   // A pulse outside FETCH, or while free-running, simply expires here.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_FETCH:  if (w_run_s || w_step_pulse) w_next = ST_DECODE;
         ST_DECODE: w_next = bus.stall ? ST_WAIT : ST_EXEC;
         ST_WAIT:   if (!bus.stall) w_next = ST_EXEC;
         ST_EXEC:   w_next = bus.halt ? ST_HALT : ST_FETCH;
         ST_HALT:   w_next = ST_HALT;
         default:   w_next = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_state     <= ST_FETCH;
         r_step_prev <= 1'b0;
         r_icount    <= '0;
      end else begin
         r_state     <= w_next;
         r_step_prev <= w_step_s;
         if (r_state == ST_EXEC && r_icount != '1) begin
            r_icount <= r_icount + 1'b1;
         end
      end
   end

   // Phase vector depends only on the state flops.
   always_comb begin
      w_cycle = '0;
      case (r_state)
         ST_FETCH:  w_cycle[CYCLE_FETCH]  = 1'b1;
         ST_DECODE: w_cycle[CYCLE_DECODE] = 1'b1;
         ST_EXEC:   w_cycle[CYCLE_EXEC]   = 1'b1;
         default:   w_cycle = '0;
      endcase
   end

   assign bus.cycle  = w_cycle;
   assign bus.halted = (r_state == ST_HALT);
   assign bus.icount = r_icount;
endmodule
